// File: rtl/env_pkg.sv
// env_pkg: shared defaults, cell/state types and saturating helpers for the
// pheromone grid.
//   DEF_*          default geometry used by env_grid_decay parameters
//   cell_t         one cell at the default signal width
//   decay_state_t  evaporation FSM states
//   sat_add/sub    width-generic (up to 16 bit) clamped arithmetic
package env_pkg;

   localparam int DEF_GRID_X      = 64;
   localparam int DEF_GRID_Y      = 48;
   localparam int DEF_SIGNAL_BITS = 4;
   localparam int DEF_NUM_WR      = 4;

   typedef struct packed {
      logic [DEF_SIGNAL_BITS-1:0] signal;
      logic                       sugar;
   } cell_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SWEEP = 2'd1,
      DONE  = 2'd2
   } decay_state_t;

   // Sum is formed one bit wider than the operands so the carry is never lost.
   function automatic logic [15:0] sat_add(input logic [15:0] a,
                                           input logic [15:0] b,
                                           input logic [15:0] max_val);
      logic [16:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return (sum > {1'b0, max_val}) ? max_val : sum[15:0];
   endfunction

   function automatic logic [15:0] sat_sub(input logic [15:0] a,
                                           input logic [15:0] b);
      return (a > b) ? (a - b) : 16'd0;
   endfunction

endpackage

// File: rtl/env_grid_decay_arb.sv
// env_rr_arbiter: single-grant round-robin arbiter.
//   clk, rst_n   clock and synchronous active-low reset
//   req          per-port request
//   grant        one-hot grant, combinational from req and the pointer,
//                forced to zero while rst_n is low
//   grant_idx    index of the granted port
//   any_grant    a grant was issued this cycle
module env_rr_arbiter
   import env_pkg::*;
#(
   parameter  int NUM_WR  = DEF_NUM_WR,
   localparam int WR_BITS = (NUM_WR > 1) ? $clog2(NUM_WR) : 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_WR-1:0]  req,
   output logic [NUM_WR-1:0]  grant,
   output logic [WR_BITS-1:0] grant_idx,
   output logic               any_grant
);

   logic [WR_BITS-1:0] rr_ptr;

   always_comb begin : p_grant
      int idx;
      idx       = 0;
      grant     = '0;
      grant_idx = '0;
      any_grant = 1'b0;
      for (int i = 0; i < NUM_WR; i++) begin
         idx = (int'(rr_ptr) + i) % NUM_WR;
         if (!any_grant && rst_n && req[idx]) begin
            any_grant = 1'b1;
            grant_idx = WR_BITS'(idx);
         end
      end
      if (any_grant) grant[grant_idx] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rr_ptr <= '0;
      end else if (any_grant) begin
         rr_ptr <= (grant_idx == WR_BITS'(NUM_WR - 1)) ? '0 : grant_idx + 1'b1;
      end
   end

endmodule

// File: rtl/env_grid_decay.sv
// env_grid_decay: GRID_X x GRID_Y pheromone/sugar register file with
// round-robin shared write ports and a row-at-a-time evaporation engine.
//   newLocClock / RESET_SIM          clock, synchronous active-low reset
//   wr_valid/ready/x/y/signal/add/sugar  NUM_WR packed write ports
//   decay_start/amount/busy/done     evaporation sweep control
//   lookup_*, render_*               two asynchronous read ports (0/0 off-grid)
//   oob_count                        saturating count of off-grid writes
//
// Decay FSM
//   state | meaning
//   IDLE  | waiting for decay_start
//   SWEEP | row_ptr row is decayed this cycle
//   DONE  | one-cycle decay_done pulse
module env_grid_decay
   import env_pkg::*;
#(
   parameter  int GRID_X      = DEF_GRID_X,
   parameter  int GRID_Y      = DEF_GRID_Y,
   parameter  int SIGNAL_BITS = DEF_SIGNAL_BITS,
   parameter  int NUM_WR      = DEF_NUM_WR,
   localparam int X_BITS      = $clog2(GRID_X),
   localparam int Y_BITS      = $clog2(GRID_Y),
   localparam int WR_BITS     = (NUM_WR > 1) ? $clog2(NUM_WR) : 1
) (
   input  logic                          newLocClock,
   input  logic                          RESET_SIM,
   input  logic [NUM_WR-1:0]             wr_valid,
   output logic [NUM_WR-1:0]             wr_ready,
   input  logic [NUM_WR*X_BITS-1:0]      wr_x,
   input  logic [NUM_WR*Y_BITS-1:0]      wr_y,
   input  logic [NUM_WR*SIGNAL_BITS-1:0] wr_signal,
   input  logic [NUM_WR-1:0]             wr_add,
   input  logic [NUM_WR-1:0]             wr_sugar,
   input  logic                          decay_start,
   input  logic [SIGNAL_BITS-1:0]        decay_amount,
   output logic                          decay_busy,
   output logic                          decay_done,
   input  logic [X_BITS-1:0]             lookup_x,
   input  logic [Y_BITS-1:0]             lookup_y,
   output logic [SIGNAL_BITS-1:0]        lookup_signal,
   output logic                          lookup_sugar,
   input  logic [X_BITS-1:0]             render_x,
   input  logic [Y_BITS-1:0]             render_y,
   output logic [SIGNAL_BITS-1:0]        render_signal,
   output logic                          render_sugar,
   output logic [7:0]                    oob_count
);

   localparam logic [15:0]     SIG_MAX = 16'((1 << SIGNAL_BITS) - 1);
   localparam logic [X_BITS:0] X_LIM   = (X_BITS + 1)'(GRID_X);
   localparam logic [Y_BITS:0] Y_LIM   = (Y_BITS + 1)'(GRID_Y);

   typedef struct packed {
      logic [SIGNAL_BITS-1:0] signal;
      logic                   sugar;
   } grid_cell_t;

   grid_cell_t grid     [GRID_Y][GRID_X];
   grid_cell_t grid_nxt [GRID_Y][GRID_X];

   decay_state_t           state, state_nxt;
   logic [Y_BITS-1:0]      row_ptr, row_nxt;
   logic [SIGNAL_BITS-1:0] amt, amt_nxt;

   logic [NUM_WR-1:0]      grant;
   logic [WR_BITS-1:0]     grant_idx;
   logic                   any_grant;

   logic [X_BITS-1:0]      sel_x;
   logic [Y_BITS-1:0]      sel_y;
   logic [SIGNAL_BITS-1:0] sel_signal;
   logic                   sel_add;
   logic                   sel_sugar;
   logic                   in_range;
   logic                   wr_hit;
   logic                   row_sweep;
   logic [SIGNAL_BITS-1:0] base;

   env_rr_arbiter #(.NUM_WR(NUM_WR)) u_arb (
      .clk       (newLocClock),
      .rst_n     (RESET_SIM),
      .req       (wr_valid),
      .grant     (grant),
      .grant_idx (grant_idx),
      .any_grant (any_grant)
   );

   assign wr_ready   = grant;
   assign sel_x      = wr_x[grant_idx*X_BITS +: X_BITS];
   assign sel_y      = wr_y[grant_idx*Y_BITS +: Y_BITS];
   assign sel_signal = wr_signal[grant_idx*SIGNAL_BITS +: SIGNAL_BITS];
   assign sel_add    = wr_add[grant_idx];
   assign sel_sugar  = wr_sugar[grant_idx];
   assign in_range   = ({1'b0, sel_x} < X_LIM) && ({1'b0, sel_y} < Y_LIM);
   assign wr_hit     = any_grant && in_range;

   always_comb begin
      state_nxt  = state;
      row_nxt    = row_ptr;
      amt_nxt    = amt;
      decay_busy = 1'b0;
      decay_done = 1'b0;
      case (state)
         IDLE: begin
            if (decay_start) begin
               amt_nxt   = decay_amount;
               row_nxt   = '0;
               state_nxt = SWEEP;
            end
         end
         SWEEP: begin
            decay_busy = 1'b1;
            if (row_ptr == Y_BITS'(GRID_Y - 1)) state_nxt = DONE;
            else                                row_nxt   = row_ptr + 1'b1;
         end
         DONE: begin
            decay_done = 1'b1;
            state_nxt  = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge newLocClock) begin
      if (!RESET_SIM) begin
         state   <= IDLE;
         row_ptr <= '0;
         amt     <= '0;
      end else begin
         state   <= state_nxt;
         row_ptr <= row_nxt;
         amt     <= amt_nxt;
      end
   end

   // A write landing in the row being swept builds on the decayed value and
   // replaces it, so that cell is decayed exactly once.
   always_comb begin
      grid_nxt  = grid;
      row_sweep = 1'b0;
      base      = '0;
      for (int y = 0; y < GRID_Y; y++) begin
         row_sweep = (state == SWEEP) && (row_ptr == Y_BITS'(y));
         for (int x = 0; x < GRID_X; x++) begin
            base = grid[y][x].signal;
            if (row_sweep) base = SIGNAL_BITS'(sat_sub(16'(base), 16'(amt)));
            if (wr_hit && sel_x == X_BITS'(x) && sel_y == Y_BITS'(y)) begin
               grid_nxt[y][x].sugar  = sel_sugar;
               grid_nxt[y][x].signal = sel_add
                  ? SIGNAL_BITS'(sat_add(16'(base), 16'(sel_signal), SIG_MAX))
                  : sel_signal;
            end else begin
               grid_nxt[y][x].signal = base;
            end
         end
      end
   end

   always_ff @(posedge newLocClock) begin
      if (!RESET_SIM) begin
         for (int y = 0; y < GRID_Y; y++)
            for (int x = 0; x < GRID_X; x++)
               grid[y][x] <= '0;
      end else begin
         grid <= grid_nxt;
      end
   end

   always_ff @(posedge newLocClock) begin
      if (!RESET_SIM)                                     oob_count <= '0;
      else if (any_grant && !in_range && oob_count != 8'hFF) oob_count <= oob_count + 8'd1;
   end

   always_comb begin
      lookup_signal = '0;
      lookup_sugar  = 1'b0;
      render_signal = '0;
      render_sugar  = 1'b0;
      if (({1'b0, lookup_x} < X_LIM) && ({1'b0, lookup_y} < Y_LIM)) begin
         lookup_signal = grid[lookup_y][lookup_x].signal;
         lookup_sugar  = grid[lookup_y][lookup_x].sugar;
      end
      if (({1'b0, render_x} < X_LIM) && ({1'b0, render_y} < Y_LIM)) begin
         render_signal = grid[render_y][render_x].signal;
         render_sugar  = grid[render_y][render_x].sugar;
      end
   end

endmodule
